// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory with a byte-stream program loader in front of the core
// Holds the core idle and feeds it NOPs until a length-prefixed little-endian program has been written.

module imem_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic [31:0] InstAdd,
    output logic [31:0] Inst,
    output logic        cpu_run,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      r_state;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len;
    logic [15:0] r_wcnt;
    logic [1:0]  r_bcnt;
    logic [23:0] r_asm;
    logic        r_in_ready;
    logic        r_cpu_run;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic [15:0] w_len;
    logic        w_len_bad;
    logic [31:0] w_word;
    logic        w_we;
    logic        w_last;
    logic [AW-1:0] w_ia;
    logic        w_in_range;
    logic        w_unused;

    // start wins over a byte offered on the same edge, so it never counts as accepted
    assign w_accept  = in_valid & r_in_ready & ~start;
    assign w_len     = {in_data, r_len_lo};
    assign w_len_bad = (w_len == 16'd0) || ({1'b0, w_len} > DEPTH_L);
    assign w_word    = {in_data, r_asm};
    assign w_we      = w_accept && (r_state == S_DATA) && (r_bcnt == 2'd3);
    assign w_last    = (r_wcnt == (r_len - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len_lo   <= 8'd0;
            r_len      <= 16'd0;
            r_wcnt     <= 16'd0;
            r_bcnt     <= 2'd0;
            r_asm      <= 24'd0;
            r_in_ready <= 1'b0;
            r_cpu_run  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else if (start) begin
            r_state    <= S_LEN_LO;
            r_wcnt     <= 16'd0;
            r_bcnt     <= 2'd0;
            r_in_ready <= 1'b1;
            r_cpu_run  <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len_lo <= in_data;
                        r_state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        if (w_len_bad) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                            r_wcnt  <= 16'd0;
                            r_bcnt  <= 2'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        // Bytes enter at the top so the first one ends up in bits [7:0]
                        r_asm  <= {in_data, r_asm[23:8]};
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_wcnt <= r_wcnt + 16'd1;
                            if (w_last) begin
                                r_state    <= S_DONE;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                                r_cpu_run  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wcnt[AW-1:0]] <= w_word;
        end
    end

    assign w_ia       = InstAdd[AW+1:2];
    assign w_in_range = (InstAdd[31:AW+2] == '0);
    assign w_unused   = ^InstAdd[1:0];

    assign Inst     = (r_cpu_run && w_in_range) ? r_mem[w_ia] : 32'h0000_0000;
    assign in_ready = r_in_ready;
    assign cpu_run  = r_cpu_run;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic [31:0] InstAdd = 32'd0;
    logic        in_ready;
    logic [31:0] Inst;
    logic        cpu_run;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .InstAdd  (InstAdd),
        .Inst     (Inst),
        .cpu_run  (cpu_run),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] wq[$];
    logic [31:0] model_mem[DEPTH];
    int checks = 0;
    int failures = 0;
    int rdy_cnt = 0;
    int acc_cnt = 0;
    int hold_viol = 0;

    always @(negedge clk) begin
        if (in_ready) rdy_cnt++;
        if (in_valid && in_ready && !start) acc_cnt++;
        if (!cpu_run && Inst !== 32'h0) hold_viol++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int n;
        if (gap_max > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(gap_max, 0)) tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        InstAdd  = 32'($urandom_range(1023, 0));
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_byte_timeout in_ready=%0b required=1", in_ready);
        end
        tick();
    endtask

    task automatic send_header(input logic [15:0] len, input int gap_max);
        send_byte(len[7:0], gap_max);
        send_byte(len[15:8], gap_max);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap_max);
    endtask

    task automatic load_wq(input int gap_max);
        int n;
        logic [31:0] w;
        n = wq.size();
        pulse_start();
        send_header(16'(n), gap_max);
        for (int k = 0; k < n; k++) begin
            w = wq[k];
            sb_q.push_back('{k, w});
            model_mem[k] = w;
            send_word(w, gap_max);
        end
        in_valid = 1'b0;
        wq.delete();
    endtask

    task automatic test_reset;
        repeat (3) tick();
        checks++;
        if ({in_ready, busy, done, err, cpu_run} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=00000", {in_ready, busy, done, err, cpu_run});
        end
        checks++;
        if (Inst !== 32'h0) begin
            failures++;
            $display("FAIL reset_inst got=%h required=00000000", Inst);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({in_ready, busy, done, err, cpu_run} !== 5'b0) begin
            failures++;
            $display("FAIL idle_outputs got=%b required=00000", {in_ready, busy, done, err, cpu_run});
        end
    endtask

    task automatic test_basic;
        sb_t e;
        wq.push_back(32'h12345678);
        wq.push_back(32'hDEADBEEF);
        rdy_cnt = 0;
        hold_viol = 0;
        load_wq(0);
        checks++;
        if (rdy_cnt !== 10) begin
            failures++;
            $display("FAIL basic_ready_cycles got=%0d required=10", rdy_cnt);
        end
        checks++;
        if ({done, cpu_run, busy, err, in_ready} !== 5'b11000) begin
            failures++;
            $display("FAIL basic_status got=%b required=11000", {done, cpu_run, busy, err, in_ready});
        end
        checks++;
        if (hold_viol !== 0) begin
            failures++;
            $display("FAIL basic_hold_nop got=%0d nonzero fetches required=0", hold_viol);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            InstAdd = 32'(e.addr * 4);
            #1;
            checks++;
            if (Inst !== e.data) begin
                failures++;
                $display("FAIL basic_inst addr=%0d got=%h required=%h", e.addr, Inst, e.data);
            end
        end
        InstAdd = 32'd5;
        #1;
        checks++;
        if (Inst !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL basic_unaligned got=%h required=deadbeef", Inst);
        end
        InstAdd = 32'h0000_0400;
        #1;
        checks++;
        if (Inst !== 32'h0) begin
            failures++;
            $display("FAIL out_of_range got=%h required=00000000", Inst);
        end
    endtask

    task automatic test_len_err;
        sb_t e;
        logic [15:0] bad [2];
        bad[0] = 16'd0;
        bad[1] = 16'(DEPTH + 1);
        for (int i = 0; i < 2; i++) begin
            pulse_start();
            send_header(bad[i], 0);
            in_valid = 1'b0;
            InstAdd = 32'd0;
            #1;
            checks++;
            if ({err, cpu_run, in_ready, busy, done} !== 5'b10000) begin
                failures++;
                $display("FAIL len_err_status len=%0d got=%b required=10000", bad[i], {err, cpu_run, in_ready, busy, done});
            end
            checks++;
            if (Inst !== 32'h0) begin
                failures++;
                $display("FAIL len_err_inst got=%h required=00000000", Inst);
            end
        end
        wq.push_back(32'hCAFEF00D);
        load_wq(0);
        checks++;
        if ({err, done, cpu_run} !== 3'b011) begin
            failures++;
            $display("FAIL len_err_recover got=%b required=011", {err, done, cpu_run});
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            InstAdd = 32'(e.addr * 4 + int'($urandom_range(3, 0)));
            #1;
            checks++;
            if (Inst !== e.data) begin
                failures++;
                $display("FAIL len_err_inst addr=%0d got=%h required=%h", e.addr, Inst, e.data);
            end
        end
    endtask

    task automatic test_stalls;
        sb_t e;
        for (int i = 0; i < 3; i++) wq.push_back($urandom);
        acc_cnt = 0;
        load_wq(3);
        checks++;
        if (acc_cnt !== 14) begin
            failures++;
            $display("FAIL stall_accept_count got=%0d required=14", acc_cnt);
        end
        checks++;
        if ({done, cpu_run} !== 2'b11) begin
            failures++;
            $display("FAIL stall_done got=%b required=11", {done, cpu_run});
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            InstAdd = 32'(e.addr * 4 + int'($urandom_range(3, 0)));
            #1;
            checks++;
            if (Inst !== e.data) begin
                failures++;
                $display("FAIL stall_inst addr=%0d got=%h required=%h", e.addr, Inst, e.data);
            end
        end
    endtask

    task automatic test_restart;
        sb_t e;
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = $urandom;
        w1 = $urandom;
        // abort on the byte that would complete word 1: word 1 must not be written
        pulse_start();
        send_header(16'd3, 0);
        send_word(w0, 0);
        model_mem[0] = w0;
        for (int b = 0; b < 3; b++) send_byte(w1[8*b +: 8], 0);
        start = 1'b1;
        in_data = w1[31:24];
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({busy, in_ready, done, err, cpu_run} !== 5'b11000) begin
            failures++;
            $display("FAIL restart_4th_status got=%b required=11000", {busy, in_ready, done, err, cpu_run});
        end
        // abort coincident with the 3rd data byte, then continue without another start
        send_header(16'd1, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        start = 1'b1;
        in_data = 8'hCC;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({busy, in_ready, done, err, cpu_run} !== 5'b11000) begin
            failures++;
            $display("FAIL restart_3rd_status got=%b required=11000", {busy, in_ready, done, err, cpu_run});
        end
        send_header(16'd1, 0);
        sb_q.push_back('{0, 32'h44332211});
        model_mem[0] = 32'h44332211;
        send_word(32'h44332211, 0);
        in_valid = 1'b0;
        checks++;
        if ({done, cpu_run} !== 2'b11) begin
            failures++;
            $display("FAIL restart_done got=%b required=11", {done, cpu_run});
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            InstAdd = 32'(e.addr * 4);
            #1;
            checks++;
            if (Inst !== e.data) begin
                failures++;
                $display("FAIL restart_inst addr=%0d got=%h required=%h", e.addr, Inst, e.data);
            end
        end
        InstAdd = 32'd4;
        #1;
        checks++;
        if (Inst !== model_mem[1]) begin
            failures++;
            $display("FAIL restart_no_write addr=1 got=%h required=%h", Inst, model_mem[1]);
        end
    endtask

    task automatic test_async_reset;
        sb_t e;
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = $urandom;
        w1 = $urandom;
        pulse_start();
        send_header(16'd3, 0);
        send_word(w0, 0);
        send_word(w1, 0);
        model_mem[0] = w0;
        model_mem[1] = w1;
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, done, err, cpu_run} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%b required=00000", {in_ready, busy, done, err, cpu_run});
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({in_ready, busy, done, err, cpu_run} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset_idle got=%b required=00000", {in_ready, busy, done, err, cpu_run});
        end
        wq.push_back($urandom);
        load_wq(0);
        for (int a = 1; a < 3; a++) sb_q.push_back('{a, model_mem[a]});
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            InstAdd = 32'(e.addr * 4);
            #1;
            checks++;
            if (Inst !== e.data) begin
                failures++;
                $display("FAIL async_reset_mem addr=%0d got=%h required=%h", e.addr, Inst, e.data);
            end
        end
    endtask

    task automatic test_full_depth;
        sb_t e;
        for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
        load_wq(0);
        checks++;
        if ({done, cpu_run, err} !== 3'b110) begin
            failures++;
            $display("FAIL full_depth_status got=%b required=110", {done, cpu_run, err});
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            InstAdd = 32'(e.addr * 4 + int'($urandom_range(3, 0)));
            #1;
            checks++;
            if (Inst !== e.data) begin
                failures++;
                $display("FAIL full_depth_inst addr=%0d got=%h required=%h", e.addr, Inst, e.data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_err();
        test_stalls();
        test_restart();
        test_async_reset();
        test_full_depth();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
